// File: rtl/cnn_window_streamer.sv
// Frame-buffered KxK window streamer: loads one raster frame over a valid/ready
// stream, then emits every fully-contained window at STRIDE with row/col tags.
module cnn_window_streamer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int STRIDE = 1,
    parameter int PW     = 8,
    parameter int CW     = 5
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                START,
    input  logic                ABORT,
    input  logic [PW-1:0]       PIX_IN,
    input  logic                PIX_VALID,
    output logic                PIX_READY,
    output logic [K*K*PW-1:0]   WIN_OUT,
    output logic                WIN_VALID,
    input  logic                WIN_READY,
    output logic [CW-1:0]       WIN_ROW,
    output logic [CW-1:0]       WIN_COL,
    output logic                WIN_LAST,
    output logic                BUSY,
    output logic                DONE
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int NX   = (IMG_W - K) / STRIDE + 1;
    localparam int NY   = (IMG_H - K) / STRIDE + 1;
    localparam logic [CW-1:0] COL_LAST = CW'((NX - 1) * STRIDE);
    localparam logic [CW-1:0] ROW_LAST = CW'((NY - 1) * STRIDE);
    localparam logic [AW-1:0] CNT_LAST = AW'(NPIX - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SCAN} state_t;

    logic [PW-1:0]     frame_mem [NPIX];
    state_t            state_reg, state_next;
    logic [AW-1:0]     cnt_reg, cnt_next;
    logic [CW-1:0]     row_reg, row_next;
    logic [CW-1:0]     col_reg, col_next;
    logic [K*K*PW-1:0] win_reg, win_mux;
    logic              done_reg, done_next;
    logic              win_load;
    logic              pix_fire, load_done, win_fire, at_last;

    assign pix_fire  = (state_reg == ST_LOAD) && PIX_VALID;
    assign load_done = pix_fire && (cnt_reg == CNT_LAST);
    assign win_fire  = (state_reg == ST_SCAN) && WIN_READY;
    assign at_last   = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (ABORT) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (START) state_next = ST_LOAD;
                ST_LOAD: if (load_done) state_next = ST_SCAN;
                ST_SCAN: if (win_fire && at_last) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        PIX_READY = (state_reg == ST_LOAD);
        WIN_VALID = (state_reg == ST_SCAN);
        BUSY      = (state_reg != ST_IDLE);
        WIN_LAST  = (state_reg == ST_SCAN) && at_last;
    end

    // Coordinates for the window that will be registered this edge; the
    // window mux reads from these so the next window is ready on handshake.
    always_comb begin
        cnt_next  = cnt_reg;
        row_next  = row_reg;
        col_next  = col_reg;
        win_load  = 1'b0;
        done_next = 1'b0;
        if (ABORT) begin
            cnt_next = '0;
            row_next = '0;
            col_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (START) cnt_next = '0;
                end
                ST_LOAD: begin
                    if (pix_fire) begin
                        if (load_done) begin
                            cnt_next = '0;
                            row_next = '0;
                            col_next = '0;
                            win_load = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + AW'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    if (win_fire) begin
                        if (at_last) begin
                            done_next = 1'b1;
                        end else begin
                            if (col_reg == COL_LAST) begin
                                col_next = '0;
                                row_next = row_reg + CW'(STRIDE);
                            end else begin
                                col_next = col_reg + CW'(STRIDE);
                            end
                            win_load = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_reg  <= '0;
            row_reg  <= '0;
            col_reg  <= '0;
            done_reg <= 1'b0;
            win_reg  <= '0;
        end else begin
            cnt_reg  <= cnt_next;
            row_reg  <= row_next;
            col_reg  <= col_next;
            done_reg <= done_next;
            if (ABORT) begin
                win_reg <= '0;
            end else if (win_load) begin
                win_reg <= win_mux;
            end
        end
    end

    // Frame buffer is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (pix_fire) begin
            frame_mem[cnt_reg] <= PIX_IN;
        end
    end

    // A tap addressing the pixel being written this edge takes PIX_IN directly,
    // so window (0,0) is correct even when it covers the final pixel.
    genvar gi, gj;
    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K; gj++) begin : g_col
                logic [AW-1:0] addr;
                assign addr = AW'(int'(row_next) * IMG_W + int'(col_next) + gi * IMG_W + gj);
                assign win_mux[(gi*K+gj)*PW +: PW] =
                    (pix_fire && (addr == cnt_reg)) ? PIX_IN : frame_mem[addr];
            end
        end
    endgenerate

    assign WIN_OUT = win_reg;
    assign WIN_ROW = row_reg;
    assign WIN_COL = col_reg;
    assign DONE    = done_reg;

endmodule

// File: tb/tb_cnn_window_streamer.sv
// Scoreboard bench: two streamers (stride 1 and stride 2) share one pixel
// stream; a frame-level reference model predicts every window per instance.
module tb_cnn_window_streamer;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int K  = 5;
    localparam int PW = 8;
    localparam int CW = 5;
    localparam int WB = K * K * PW;

    logic          CLK = 1'b0;
    logic          nRST, START, ABORT, PIX_VALID;
    logic [PW-1:0] PIX_IN;
    logic [1:0]    pix_ready, win_valid, win_ready, win_last, busy, done;
    logic [WB-1:0] win_out0, win_out1;
    logic [CW-1:0] win_row0, win_row1, win_col0, win_col1;

    always #5 CLK = ~CLK;

    cnn_window_streamer #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(1), .PW(PW), .CW(CW)) dut0 (
        .CLK(CLK), .nRST(nRST), .START(START), .ABORT(ABORT),
        .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID), .PIX_READY(pix_ready[0]),
        .WIN_OUT(win_out0), .WIN_VALID(win_valid[0]), .WIN_READY(win_ready[0]),
        .WIN_ROW(win_row0), .WIN_COL(win_col0), .WIN_LAST(win_last[0]),
        .BUSY(busy[0]), .DONE(done[0])
    );

    cnn_window_streamer #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(2), .PW(PW), .CW(CW)) dut1 (
        .CLK(CLK), .nRST(nRST), .START(START), .ABORT(ABORT),
        .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID), .PIX_READY(pix_ready[1]),
        .WIN_OUT(win_out1), .WIN_VALID(win_valid[1]), .WIN_READY(win_ready[1]),
        .WIN_ROW(win_row1), .WIN_COL(win_col1), .WIN_LAST(win_last[1]),
        .BUSY(busy[1]), .DONE(done[1])
    );

    typedef struct {
        logic [WB-1:0] win;
        int            row;
        int            col;
        bit            last;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [PW-1:0] img [W*H];
    int            checks = 0;
    int            failures = 0;
    int            hs_cnt [2];
    bit            frame_done [2];
    bit            expect_done [2];
    bit            prev_stall [2];
    logic [WB-1:0] prev_win [2];
    logic [CW-1:0] prev_row [2];
    logic [CW-1:0] prev_col [2];
    logic          prev_last [2];
    bit            rand_ready = 1'b0;

    task automatic chk(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s", msg);
        end
    endtask

    // Reference: every top-left (r,c) with the window fully inside the frame.
    task automatic push_windows(input int id, input int stride);
        for (int r = 0; r + K <= H; r += stride) begin
            for (int c = 0; c + K <= W; c += stride) begin
                exp_t e;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        e.win[(i*K+j)*PW +: PW] = img[(r+i)*W + c + j];
                e.row  = r;
                e.col  = c;
                e.last = (r + stride + K > H) && (c + stride + K > W);
                if (id == 0) q0.push_back(e);
                else         q1.push_back(e);
            end
        end
    endtask

    task automatic mon(input int id, input logic v, input logic rdy, input logic lst,
                       input logic dn, input logic [WB-1:0] w,
                       input logic [CW-1:0] r, input logic [CW-1:0] c);
        exp_t e;
        bit   have;
        if (expect_done[id]) begin
            chk(dn && !v, $sformatf("done%0d: DONE=%0b WIN_VALID=%0b want 1/0", id, dn, v));
            expect_done[id] = 1'b0;
            frame_done[id]  = 1'b1;
        end else begin
            chk(!dn, $sformatf("spurious_done%0d: DONE=%0b want 0", id, dn));
        end
        if (prev_stall[id] && v) begin
            chk(w == prev_win[id] && r == prev_row[id] && c == prev_col[id] && lst == prev_last[id],
                $sformatf("stall%0d: got row=%0d col=%0d last=%0b want row=%0d col=%0d last=%0b (held)",
                          id, r, c, lst, prev_row[id], prev_col[id], prev_last[id]));
        end
        if (v && rdy) begin
            have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
            chk(have, $sformatf("extra_win%0d: got row=%0d col=%0d want no window", id, r, c));
            if (have) begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk(w == e.win && int'(r) == e.row && int'(c) == e.col && lst == e.last,
                    $sformatf("win%0d #%0d: got row=%0d col=%0d last=%0b win=%h want row=%0d col=%0d last=%0b win=%h",
                              id, hs_cnt[id], r, c, lst, w, e.row, e.col, e.last, e.win));
                hs_cnt[id]++;
                if (e.last) expect_done[id] = 1'b1;
            end
        end
        prev_stall[id] = v && !rdy;
        prev_win[id]   = w;
        prev_row[id]   = r;
        prev_col[id]   = c;
        prev_last[id]  = lst;
    endtask

    always @(negedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < 2; i++) begin
                prev_stall[i]  = 1'b0;
                expect_done[i] = 1'b0;
            end
        end else begin
            mon(0, win_valid[0], win_ready[0], win_last[0], done[0], win_out0, win_row0, win_col0);
            mon(1, win_valid[1], win_ready[1], win_last[1], done[1], win_out1, win_row1, win_col1);
        end
    end

    initial begin
        win_ready = 2'b11;
        forever begin
            @(posedge CLK);
            #1;
            win_ready = rand_ready ? 2'($urandom_range(0, 3)) : 2'b11;
        end
    end

    task automatic fill(input int mode);
        for (int n = 0; n < W*H; n++) begin
            case (mode)
                0:       img[n] = PW'(n % 256);
                1:       img[n] = PW'(255 - (n % 256));
                default: img[n] = PW'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic start_frame(input bit expect_windows);
        hs_cnt[0] = 0;
        hs_cnt[1] = 0;
        frame_done[0] = 1'b0;
        frame_done[1] = 1'b0;
        if (expect_windows) begin
            push_windows(0, 1);
            push_windows(1, 2);
        end
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk(busy == 2'b11 && pix_ready == 2'b11,
            $sformatf("load_entry: BUSY=%b PIX_READY=%b want 11/11", busy, pix_ready));
    endtask

    task automatic feed(input int gap, input int count);
        for (int n = 0; n < count; n++) begin
            PIX_VALID = 1'b0;
            repeat (gap) begin @(posedge CLK); #1; end
            PIX_VALID = 1'b1;
            PIX_IN    = img[n];
            if (n == W*H - 1)
                chk(pix_ready == 2'b11, $sformatf("ready_last_pix: PIX_READY=%b want 11", pix_ready));
            @(posedge CLK); #1;
        end
        PIX_VALID = 1'b0;
        if (count == W*H)
            chk(pix_ready == 2'b00 && win_valid == 2'b11,
                $sformatf("scan_entry: PIX_READY=%b WIN_VALID=%b want 00/11", pix_ready, win_valid));
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 30000 && !(frame_done[0] && frame_done[1]); i++) begin
            @(posedge CLK); #1;
        end
        chk(frame_done[0] && frame_done[1],
            $sformatf("frame_timeout: done flags=%0b%0b want 11", frame_done[1], frame_done[0]));
        chk(hs_cnt[0] == 576, $sformatf("count0: got %0d handshakes want 576", hs_cnt[0]));
        chk(hs_cnt[1] == 144, $sformatf("count1: got %0d handshakes want 144", hs_cnt[1]));
        chk(q0.size() == 0 && q1.size() == 0,
            $sformatf("leftover: q0=%0d q1=%0d want 0/0", q0.size(), q1.size()));
        chk(busy == 2'b00, $sformatf("idle_after_done: BUSY=%b want 00", busy));
    endtask

    task automatic wait_hs(input int n);
        for (int i = 0; i < 5000 && hs_cnt[0] < n; i++) begin
            @(posedge CLK); #1;
        end
        chk(hs_cnt[0] >= n, $sformatf("hs_timeout: got %0d handshakes want %0d", hs_cnt[0], n));
    endtask

    function automatic bit all_zero();
        return pix_ready == 2'b00 && win_valid == 2'b00 && win_last == 2'b00 &&
               busy == 2'b00 && done == 2'b00 && win_out0 == '0 && win_out1 == '0 &&
               win_row0 == '0 && win_row1 == '0 && win_col0 == '0 && win_col1 == '0;
    endfunction

    initial begin
        nRST = 1'b0; START = 1'b0; ABORT = 1'b0; PIX_VALID = 1'b0; PIX_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk(all_zero(), $sformatf("reset: BUSY=%b WIN_VALID=%b PIX_READY=%b DONE=%b row0=%0d col0=%0d want all 0",
                                  busy, win_valid, pix_ready, done, win_row0, win_col0));
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Ramp frame at full throughput.
        fill(0);
        start_frame(1'b1);
        feed(0, W*H);
        wait_frame();

        // Inverted ramp, sparse pixels, random back-pressure, stray START mid-scan.
        fill(1);
        rand_ready = 1'b1;
        start_frame(1'b1);
        feed(2, W*H);
        wait_hs(10);
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk(busy == 2'b11, $sformatf("start_ignored: BUSY=%b want 11", busy));
        wait_frame();

        // Asynchronous reset in the middle of a scan.
        fill(2);
        rand_ready = 1'b0;
        start_frame(1'b1);
        feed(0, W*H);
        wait_hs(100);
        #2;
        nRST = 1'b0;
        #1;
        chk(all_zero(), $sformatf("mid_scan_reset: BUSY=%b WIN_VALID=%b row0=%0d col0=%0d want all 0",
                                  busy, win_valid, win_row0, win_col0));
        q0.delete();
        q1.delete();
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        chk(busy == 2'b00, $sformatf("post_reset_idle: BUSY=%b want 00", busy));

        // ABORT part-way through loading.
        fill(2);
        start_frame(1'b0);
        feed(0, 300);
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        chk(busy == 2'b00 && pix_ready == 2'b00 && win_valid == 2'b00,
            $sformatf("abort_load: BUSY=%b PIX_READY=%b WIN_VALID=%b want 00/00/00", busy, pix_ready, win_valid));
        repeat (3) begin @(posedge CLK); #1; end

        // ABORT and START together in IDLE keep the block idle.
        START = 1'b1;
        ABORT = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        ABORT = 1'b0;
        chk(busy == 2'b00 && pix_ready == 2'b00,
            $sformatf("abort_start: BUSY=%b PIX_READY=%b want 00/00", busy, pix_ready));

        // Fresh frame after abort completes normally.
        fill(2);
        rand_ready = 1'b1;
        start_frame(1'b1);
        feed(1, W*H);
        wait_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
